// File: rtl/sound_ioreg_sequencer_pkg.sv
// sound_seq_defs: op codes, FSM states and sound IO-register addresses shared by the sequencer and its users
package sound_seq_defs;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_WAIT = 2'b01, OP_JUMP = 2'b10, OP_END = 2'b11} op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_WAIT, S_HALT} state_e;
  localparam logic [7:0] IOREG_BASE = 8'hFF;
  localparam logic [15:0] NR10 = 16'hFF10;
  localparam logic [15:0] NR52 = 16'hFF26;
  localparam logic [15:0] WAVE_LO = 16'hFF30;
endpackage

// File: rtl/sound_script_rom.sv
// sound_script_rom: synchronous script ROM, one-cycle read latency, contents given by parameter
module sound_script_rom #(
  parameter int ADDR_W = 6,
  parameter logic [23:0] ROM_INIT [2**ADDR_W] = '{default: 24'h0}
) (
  input  logic              I_CLK,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [23:0]       data_o
);
  always_ff @(posedge I_CLK) data_o <= ROM_INIT[addr_i];
endmodule

// File: rtl/sound_ioreg_sequencer.sv
// sound_ioreg_sequencer: fetches 24-bit script commands and issues timed writes on the sound IO-register bus
module sound_ioreg_sequencer
  import sound_seq_defs::*;
#(
  parameter int ADDR_W = 6,
  parameter int WAIT_SCALE = 1024,
  parameter int CNT_W = 26,
  parameter bit USE_ROM = 1'b0,
  parameter logic [23:0] ROM_INIT [2**ADDR_W] = '{default: 24'h0}
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_START,
  input  logic              I_STOP,
  output logic [ADDR_W-1:0] O_ROM_ADDR,
  input  logic [23:0]       I_ROM_DATA,
  output logic [15:0]       O_IOREG_ADDR,
  output logic [7:0]        O_IOREG_DATA,
  output logic              O_IOREG_EN,
  output logic              O_IOREG_WE_L,
  output logic              O_IOREG_RE_L,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [7:0]        O_LOOP_COUNT
);
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       addr_q;
  logic [7:0]        data_q;
  logic              en_q;
  logic              we_l_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        loop_q;
  logic [23:0]       word;
  logic [15:0]       arg;
  logic [CNT_W-1:0]  wait_load;
  logic              unused_rsvd;

  if (USE_ROM) begin : g_rom
    sound_script_rom #(.ADDR_W(ADDR_W), .ROM_INIT(ROM_INIT)) u_rom (
      .I_CLK (I_CLK),
      .addr_i(pc_q),
      .data_o(word)
    );
  end else begin : g_ext
    assign word = I_ROM_DATA;
  end

  assign arg         = word[15:0];
  assign unused_rsvd = ^word[21:16];
  assign wait_load   = CNT_W'(arg) * CNT_W'(WAIT_SCALE) - CNT_W'(1);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      we_l_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      loop_q  <= '0;
    end else if (I_STOP) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      we_l_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      we_l_q <= 1'b1;
      case (state_q)
        S_IDLE, S_HALT: if (I_START) begin
          state_q <= S_FETCH;
          pc_q    <= '0;
          loop_q  <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: case (op_e'(word[23:22]))
          OP_WRITE: begin
            state_q <= S_WRITE;
            addr_q  <= {IOREG_BASE, arg[15:8]};
            data_q  <= arg[7:0];
            en_q    <= 1'b1;
            we_l_q  <= 1'b0;
          end
          OP_WAIT: begin
            state_q <= (arg == '0) ? S_FETCH : S_WAIT;
            pc_q    <= (arg == '0) ? pc_q + ADDR_W'(1) : pc_q;
            cnt_q   <= wait_load;
          end
          OP_JUMP: begin
            state_q <= S_FETCH;
            pc_q    <= arg[ADDR_W-1:0];
            loop_q  <= loop_q + 8'd1;
          end
          default: begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        endcase
        S_WRITE: begin
          state_q <= S_FETCH;
          pc_q    <= pc_q + ADDR_W'(1);
        end
        S_WAIT: begin
          state_q <= (cnt_q == '0) ? S_FETCH : S_WAIT;
          pc_q    <= (cnt_q == '0) ? pc_q + ADDR_W'(1) : pc_q;
          cnt_q   <= (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_ROM_ADDR   = pc_q;
  assign O_IOREG_ADDR = addr_q;
  assign O_IOREG_DATA = data_q;
  assign O_IOREG_EN   = en_q;
  assign O_IOREG_WE_L = we_l_q;
  assign O_IOREG_RE_L = 1'b1;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_LOOP_COUNT = loop_q;
endmodule
